// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module      : uart_baud_gen
// Description : 16x-oversample baud strobe, phase index and bit strobes
//               selected from a table of standard UART rates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_gen #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] Baud_Rate,
    output logic [3:0]  tick,
    output logic [3:0]  tick_spike
);

    localparam int c_PRESC_W = 13;

    localparam logic [c_PRESC_W-1:0] c_DIV_1200   = c_PRESC_W'(CLK_FREQ / (OVERSAMPLE * 1200));
    localparam logic [c_PRESC_W-1:0] c_DIV_2400   = c_PRESC_W'(CLK_FREQ / (OVERSAMPLE * 2400));
    localparam logic [c_PRESC_W-1:0] c_DIV_4800   = c_PRESC_W'(CLK_FREQ / (OVERSAMPLE * 4800));
    localparam logic [c_PRESC_W-1:0] c_DIV_9600   = c_PRESC_W'(CLK_FREQ / (OVERSAMPLE * 9600));
    localparam logic [c_PRESC_W-1:0] c_DIV_14400  = c_PRESC_W'(CLK_FREQ / (OVERSAMPLE * 14400));
    localparam logic [c_PRESC_W-1:0] c_DIV_19200  = c_PRESC_W'(CLK_FREQ / (OVERSAMPLE * 19200));
    localparam logic [c_PRESC_W-1:0] c_DIV_38400  = c_PRESC_W'(CLK_FREQ / (OVERSAMPLE * 38400));
    localparam logic [c_PRESC_W-1:0] c_DIV_57600  = c_PRESC_W'(CLK_FREQ / (OVERSAMPLE * 57600));
    localparam logic [c_PRESC_W-1:0] c_DIV_115200 = c_PRESC_W'(CLK_FREQ / (OVERSAMPLE * 115200));

    localparam logic [3:0] c_TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] c_TICK_LAST = 4'(OVERSAMPLE - 1);

    logic [16:0]          rate_q, rate_d;
    logic [16:0]          prev_rate_q, prev_rate_d;
    logic                 valid_prev_q, valid_prev_d;
    logic [c_PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]           tick_q, tick_d;
    logic [2:0]           strobe_q, strobe_d;
    logic                 flag_q, flag_d;

    logic [c_PRESC_W-1:0] w_div;
    logic                 w_rate_valid;
    logic                 w_rate_change;

    always_comb begin
        w_div        = {{(c_PRESC_W-1){1'b0}}, 1'b1};
        w_rate_valid = 1'b1;
        case (rate_q)
            17'd1200:   w_div = c_DIV_1200;
            17'd2400:   w_div = c_DIV_2400;
            17'd4800:   w_div = c_DIV_4800;
            17'd9600:   w_div = c_DIV_9600;
            17'd14400:  w_div = c_DIV_14400;
            17'd19200:  w_div = c_DIV_19200;
            17'd38400:  w_div = c_DIV_38400;
            17'd57600:  w_div = c_DIV_57600;
            17'd115200: w_div = c_DIV_115200;
            default:    w_rate_valid = 1'b0;
        endcase
    end

    // A change is only a restart when the previous rate was running; coming
    // out of reset or an invalid rate the counters already sit at zero.
    assign w_rate_change = valid_prev_q && (rate_q != prev_rate_q);

    always_comb begin
        rate_d       = Baud_Rate;
        prev_rate_d  = rate_q;
        valid_prev_d = w_rate_valid;
        presc_d      = presc_q;
        tick_d       = tick_q;
        strobe_d     = 3'b000;
        flag_d       = !w_rate_valid;

        if (!w_rate_valid || w_rate_change) begin
            presc_d = '0;
            tick_d  = '0;
        end else if (presc_q == w_div - 1'b1) begin
            presc_d     = '0;
            tick_d      = tick_q + 4'd1;
            strobe_d[0] = 1'b1;
            strobe_d[1] = (tick_q == c_TICK_LAST);
            strobe_d[2] = (tick_q == c_TICK_MID);
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_q       <= '0;
            prev_rate_q  <= '0;
            valid_prev_q <= 1'b0;
            presc_q      <= '0;
            tick_q       <= '0;
            strobe_q     <= '0;
            flag_q       <= 1'b0;
        end else begin
            rate_q       <= rate_d;
            prev_rate_q  <= prev_rate_d;
            valid_prev_q <= valid_prev_d;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            strobe_q     <= strobe_d;
            flag_q       <= flag_d;
        end
    end

    assign tick       = tick_q;
    assign tick_spike = {flag_q, strobe_q};

endmodule

`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
// ============================================================================
// Module      : tb_uart_baud_gen
// Description : Self-checking bench for uart_baud_gen with a timing model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_baud_gen;

    localparam int c_CLK_HZ = 100_000_000;

    typedef struct {
        int rate;
        int div;
        bit valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] Baud_Rate = 17'd1200;
    logic [3:0]  tick;
    logic [3:0]  tick_spike;

    int n_assert = 0;
    int n_fail   = 0;

    int supported [9] = '{1200, 2400, 4800, 9600, 14400, 19200, 38400, 57600, 115200};

    // Reference model state: a running rate is a segment starting at some
    // edge; everything after that is plain modulo arithmetic on edge counts.
    int unsigned edge_cnt  = 0;
    int unsigned seg_start = 0;
    int unsigned seg_div   = 1;
    bit          seg_on    = 1'b0;
    int          m_rate    = 0;
    int          m_prev    = 0;
    bit          m_flag    = 1'b0;

    uart_baud_gen #(
        .CLK_FREQ   (c_CLK_HZ),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Baud_Rate  (Baud_Rate),
        .tick       (tick),
        .tick_spike (tick_spike)
    );

    always #5 clk = ~clk;

    function automatic bit is_sup(input int r);
        for (int i = 0; i < 9; i++)
            if (supported[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int ref_div(input int r);
        return c_CLK_HZ / (16 * r);
    endfunction

    function automatic logic [7:0] expect_out();
        int unsigned n;
        int unsigned k;
        logic [3:0]  t;
        logic [3:0]  s;
        t = 4'd0;
        s = 4'd0;
        if (seg_on) begin
            n = edge_cnt - seg_start;
            k = n / seg_div;
            t = 4'(k % 16);
            if (n != 0 && (n % seg_div) == 0)
                s[2:0] = {t == 4'd8, t == 4'd0, 1'b1};
        end
        s[3] = m_flag;
        return {t, s};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_spike(input int idx, input int limit, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!tick_spike[idx] && cnt < limit);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                edge_cnt = 0;
                seg_on   = 1'b0;
                m_rate   = 0;
                m_prev   = 0;
                m_flag   = 1'b0;
            end else begin
                edge_cnt++;
                if (!is_sup(m_rate) && is_sup(int'(Baud_Rate))) begin
                    seg_on    = 1'b1;
                    seg_start = edge_cnt;
                    seg_div   = ref_div(int'(Baud_Rate));
                end else if (!is_sup(m_rate)) begin
                    seg_on = 1'b0;
                end else if (is_sup(m_prev) && m_prev != m_rate) begin
                    seg_on    = 1'b1;
                    seg_start = edge_cnt;
                    seg_div   = ref_div(m_rate);
                end
                m_flag = !is_sup(m_rate);
                m_prev = m_rate;
                m_rate = int'(Baud_Rate);
            end
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            e = expect_out();
            check("model_tick", tick, e[7:4]);
            check("model_spike", tick_spike, e[3:0]);
        end
    end

    initial begin
        vec_t vecs [12];
        int   pool [8] = '{115200, 57600, 38400, 19200, 14400, 1000, 0, 12345};
        int   cnt;
        bit   prev_valid;

        vecs[0]  = '{57600,  108,  1'b1};
        vecs[1]  = '{38400,  162,  1'b1};
        vecs[2]  = '{19200,  325,  1'b1};
        vecs[3]  = '{14400,  434,  1'b1};
        vecs[4]  = '{4800,   1302, 1'b1};
        vecs[5]  = '{1000,   0,    1'b0};
        vecs[6]  = '{9600,   651,  1'b1};
        vecs[7]  = '{2400,   2604, 1'b1};
        vecs[8]  = '{1200,   5208, 1'b1};
        vecs[9]  = '{0,      0,    1'b0};
        vecs[10] = '{115200, 54,   1'b1};
        vecs[11] = '{70000,  0,    1'b0};

        // Reset state and first strobe after release at 1200 baud
        repeat (3) @(negedge clk);
        check("reset_tick", tick, 0);
        check("reset_spike", tick_spike, 0);
        rst = 1'b0;
        wait_spike(0, 6000, cnt);
        check("first_strobe_latency", cnt, 5209);
        check("tick_after_first", tick, 1);
        wait_spike(0, 6000, cnt);
        check("period_1200", cnt, 5208);

        // Mid-bit change 1200 -> 2400 -> 4800
        repeat (1000) @(posedge clk);
        @(negedge clk);
        Baud_Rate = 17'd2400;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("tick_cleared_on_change", tick, 0);
        wait_spike(0, 3000, cnt);
        check("first_strobe_2400", cnt, 2604);
        wait_spike(0, 3000, cnt);
        check("period_2400", cnt, 2604);
        @(negedge clk);
        Baud_Rate = 17'd4800;
        wait_spike(0, 2000, cnt);
        check("first_strobe_4800", cnt, 1304);
        wait_spike(0, 2000, cnt);
        check("period_4800", cnt, 1302);

        // Bit-end and mid-bit spacing at 115200
        @(negedge clk);
        Baud_Rate = 17'd115200;
        wait_spike(1, 2000, cnt);
        wait_spike(2, 1000, cnt);
        check("bitend_to_mid_115200", cnt, 432);
        wait_spike(1, 1000, cnt);
        check("mid_to_bitend_115200", cnt, 432);
        wait_spike(1, 1000, cnt);
        check("bit_period_115200", cnt, 864);

        // Table sweep over all rates plus unsupported values
        prev_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            Baud_Rate = 17'(vecs[i].rate);
            if (vecs[i].valid) begin
                wait_spike(0, vecs[i].div + 10, cnt);
                check($sformatf("latency_%0d", vecs[i].rate), cnt,
                      prev_valid ? vecs[i].div + 2 : vecs[i].div + 1);
                wait_spike(0, vecs[i].div + 10, cnt);
                check($sformatf("period_%0d", vecs[i].rate), cnt, vecs[i].div);
            end else begin
                repeat (20) @(posedge clk);
                #1;
                check($sformatf("invalid_spike_%0d", vecs[i].rate), tick_spike, 4'b1000);
                check($sformatf("invalid_tick_%0d", vecs[i].rate), tick, 0);
            end
            prev_valid = vecs[i].valid;
        end

        // Asynchronous reset between edges, then restart latency
        @(negedge clk);
        Baud_Rate = 17'd9600;
        wait_spike(0, 1000, cnt);
        repeat (100) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_tick", tick, 0);
        check("async_rst_spike", tick_spike, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_spike(0, 1000, cnt);
        check("rst_restart_latency", cnt, 652);

        // Random rate changes and reset pulses against the model
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            Baud_Rate = 17'(pool[$urandom_range(0, 7)]);
            repeat ($urandom_range(100, 1500)) @(posedge clk);
            if ($urandom_range(0, 4) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                check("rand_async_rst", {tick, tick_spike}, 0);
                @(negedge clk);
                rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Baud-rate timing generator for the UART transmitter and receiver.
- Divides the system clock down to a 16x-oversample strobe for the selected standard baud rate.
- Also provides the oversample phase index, a bit-boundary strobe, a mid-bit sample strobe and an invalid-rate flag.
- Sits between the UART configuration register and the TX/RX shift-register FSMs.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz; divisor table entries = CLK_FREQ / (16 * rate), truncated.
- OVERSAMPLE, 16, oversample ticks per bit; fixed, defines the 4-bit tick width.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high.
- Baud_Rate  input  17  requested baud rate in bit/s, unsigned decimal, e.g. 1200.
- tick  output  4  oversample phase index 0..15 within the current bit.
- tick_spike  output  4  single-cycle strobes and flag, bit fields as listed below:
  - [0] oversample strobe
  - [1] bit-end strobe
  - [2] mid-bit strobe
  - [3] invalid-rate flag (level)

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high. All state is registered.
- Reset values: prescaler = 0, tick = 0, tick_spike = 4'b0000, latched rate = 0.
- Supported rates and divisors at 100 MHz:
  - 1200 -> 5208
  - 2400 -> 2604
  - 4800 -> 1302
  - 9600 -> 651
  - 14400 -> 434
  - 19200 -> 325
  - 38400 -> 162
  - 57600 -> 108
  - 115200 -> 54
- Divisor is a combinational lookup on a registered copy of Baud_Rate; the prescaler is 13 bits wide.
- Any other Baud_Rate value is invalid:
  - tick_spike[3] = 1;
  - prescaler and tick held at 0;
  - tick_spike[2:0] = 0.
- Prescaler:
  - increments every clk;
  - when prescaler == divisor-1 it wraps to 0 and tick_spike[0] pulses high for exactly one cycle (the cycle after the wrap edge);
  - period of tick_spike[0] is exactly divisor cycles.
- tick: advances by 1 on each oversample strobe, mod 16 (15 -> 0).
- tick_spike[1]: one-cycle pulse coincident with the oversample strobe that wraps tick 15 -> 0. Period = 16*divisor cycles.
- tick_spike[2]: one-cycle pulse coincident with the oversample strobe that moves tick 7 -> 8 (bit centre).
- Rate change:
  - the registered Baud_Rate differs from its previous value for one cycle;
  - on that cycle prescaler and tick clear to 0 and no strobe is issued;
  - counting restarts with the new divisor from the next cycle, so the first new strobe arrives divisor cycles later.
- First oversample strobe after reset release (Baud_Rate stable) occurs divisor+1 cycles after deassertion: one cycle to latch the rate, plus divisor counts.
- Reset asserted mid-count immediately clears all outputs, independent of clk.
- No overflow path: the largest divisor (5208) fits in the 13-bit prescaler.

Test Plan:
- Rst high, Baud_Rate=1200, release rst → tick_spike[0] pulses every 5208 cycles. tick reads 1 after the first strobe. tick_spike[1] first pulses on the 16th strobe (83328 cycles after the first counting cycle). After 40 strobes (208320 cycles) tick=8.
- Baud_Rate=1200 running → tick_spike[2] pulses on the strobe where tick 7->8, exactly 8*5208 cycles after each tick_spike[1] pulse; never coincident with tick_spike[1].
- Change Baud_Rate 1200->2400 mid-bit → tick=0 the cycle after the rate is registered. Next strobe 2604 cycles later. Bit strobe period becomes 41664 cycles. Then 2400->4800 gives a strobe period of 1302 cycles.
- Baud_Rate=115200 → strobe period 54 cycles, bit period 864 cycles. Sweep all nine table rates and check each strobe period equals its divisor.
- Baud_Rate=1000 (unsupported) → tick_spike=4'b1000, tick=0 held. Return to 9600 → flag clears and strobes resume at a period of 651 cycles.
- Assert rst asynchronously between clock edges mid-count → tick and tick_spike are 0 before the next edge. After release, the first strobe comes divisor+1 cycles later.
